mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the core's instruction-fetch port and its load/store port.
//  Sits between the mipsCore I/D cache interfaces and a unified memory. Runs a non-pipelined
//  request/ack protocol, one transaction outstanding at a time.
//  Arbitration gives data priority, with a starvation guard for fetch. Drives a stall to the core.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive lost arbitrations after which fetch wins (>=1)
//  TIMEOUT_CYC   64  max cycles waiting for mem_ready (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  if_req     in   1   fetch request; held high until if_ack
//  if_addr    in   AW  fetch address; stable while if_req
//  if_ack     out  1   one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DW  fetch data (registered)
//  if_err     out  1   with if_ack: fetch timed out
//  d_req      in   1   data request; held high until d_ack
//  d_we       in   1   1=store, 0=load; stable while d_req
//  d_addr     in   AW  data address; stable while d_req
//  d_wdata    in   DW  store data; stable while d_req
//  d_ack      out  1   one-cycle pulse: data access complete
//  d_rdata    out  DW  load data (registered)
//  d_err      out  1   with d_ack: data access timed out
//  mem_req    out  1   memory request; high for entire access until mem_ready
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address (registered at grant)
//  mem_wdata  out  DW  memory write data (registered at grant)
//  mem_ready  in   1   memory completes access this cycle; mem_rdata valid
//  mem_rdata  in   DW  memory read data
//  core_stall out  1   high when (if_req & ~if_ack) | (d_req & ~d_ack)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except core_stall, which is combinational. starve_cnt=0. tmo_cnt=0.
//  FSM: IDLE -> BUSY_I | BUSY_D on grant. BUSY_x -> RESP_x when mem_ready. RESP_x -> IDLE.
//  Grant in IDLE:
//   - d_req & (~if_req | starve_cnt<STARVE_LIMIT) -> BUSY_D.
//   - else if_req -> BUSY_I.
//  At grant, mem_addr, mem_we and mem_wdata are latched. mem_we=0 for fetch.
//  mem_req=1 throughout BUSY_x. Outputs are ignored and held when mem_req=0.
//  On mem_ready in BUSY_x, mem_rdata is captured into x_rdata.
//  RESP_x: x_ack=1 for exactly one cycle. No grant is made in RESP.
//   - This guarantees a requester dropping req on ack is never re-granted.
//   - d_rdata is undefined-but-stable for stores; the RTL writes 0.
//  Latency: req seen in IDLE at cycle 0, mem_req at cycle 1.
//   - Zero-wait memory (mem_ready in cycle 1) gives ack in cycle 2.
//   - Each mem wait cycle adds 1.
//  Back-to-back: one idle cycle (IDLE) between transactions. Sustained throughput is one access per 3 cycles.
//  starve_cnt:
//   - +1 (saturating at STARVE_LIMIT) on each grant to D while if_req=1.
//   - Cleared on every grant to I.
//   - Unchanged otherwise.
//  Simultaneous if_req&d_req with starve_cnt==STARVE_LIMIT: I wins, counter clears, D waits one transaction.
//  mem_ready outside BUSY_x: ignored.
//  req deasserted while BUSY (protocol violation): transaction still completes; ack still pulses.
//  rst mid-transaction: immediate return to IDLE, mem_req=0, no ack. The in-flight access is abandoned.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - tmo_cnt counts BUSY cycles and clears on entering BUSY.
//   - If it reaches TIMEOUT_CYC with no mem_ready: mem_req drops, go RESP_x, x_ack=1 with x_err=1, x_rdata=0.
//   - mem_ready in the same cycle as timeout wins (normal completion, err=0).
//  ARB_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely.
//   - if_err and d_err are tied to 0. Ports are always present.
// TESTING
//  1. Lone fetch, zero-wait mem, if_addr=0x40, mem_rdata=0x2002000A
//     -> mem_req at c1 with addr 0x40, we=0; if_ack at c2; if_rdata=0x2002000A; core_stall 1 at c0-c1, 0 at c2.
//  2. Store d_addr=0x100, d_wdata=0xCAFEF00D, mem_ready after 3 waits
//     -> mem_req high 4 cycles, mem_we=1, wdata=0xCAFEF00D; d_ack pulses once; d_err=0.
//  3. if_req & d_req held continuously, STARVE_LIMIT=4
//     -> grant order D,D,D,D,I,D,D,D,D,I; no transaction is lost or duplicated.
//  4. d_req held, if_req dropped after ack, then reasserted
//     -> starve_cnt clears on the I grant; D never re-granted in RESP; one ack per req.
//  5. rst asserted in BUSY_D cycle 2
//     -> mem_req=0 asynchronously, no d_ack; after release, a fresh d_req completes normally.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ready never asserted
//     -> mem_req low after 8 BUSY cycles; d_ack=1 & d_err=1, d_rdata=0. Undefined build: still waiting at cycle 100.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; data wins unless fetch starves
// Optional: define ARB_TIMEOUT_EN to abort accesses that never see mem_ready (adds TIMEOUT_CYC parameter).
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_stall
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          grant_d;

  // Data wins unless fetch has already lost STARVE_LIMIT times in a row.
  assign grant_d    = d_req & (~if_req | (starve_cnt < STARVE_MAX));
  assign core_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      if_err     <= 1'b0;
      d_err      <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      if_err <= 1'b0;
      d_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (if_req) begin
            state      <= BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              state    <= RESP_I;
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              state   <= RESP_D;
              d_ack   <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              state    <= RESP_I;
              if_ack   <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end else begin
              state   <= RESP_D;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        // No grant here, so a requester dropping req on its ack is never re-served.
        RESP_I, RESP_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        core_stall;

  int          checks   = 0;
  int          failures = 0;
  int          mem_wait = 0;
  bit          mem_en   = 1'b1;
  logic [31:0] rd_xor   = 32'h2002004A;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(4)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .core_stall(core_stall)
  );

  // Memory responder: mem_wait wait cycles, then one ready cycle with data = addr ^ rd_xor.
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_en) begin
        if (wcnt >= mem_wait) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr ^ rd_xor;
          wcnt      = 0;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if_ack, if_err, d_ack, d_err, mem_req, mem_we} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {if_ack, if_err, d_ack, d_err, mem_req, mem_we});
    end
    checks++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata});
    end
    checks++;
    if (core_stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", core_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lone_fetch();
    mem_wait = 0;
    if_req = 1; if_addr = 32'h40;
    #1;
    checks++;
    if (core_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0 got=%b exp=1", core_stall); end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      failures++; $display("FAIL fetch_mem_c1 got req=%b we=%b addr=%h exp req=1 we=0 addr=00000040", mem_req, mem_we, mem_addr);
    end
    checks++;
    if ({core_stall, if_ack} !== 2'b10) begin failures++; $display("FAIL fetch_c1 got stall/ack=%b exp=10", {core_stall, if_ack}); end
    @(negedge clk);
    checks++;
    if ({if_ack, core_stall, if_err, mem_req} !== 4'b1000) begin
      failures++; $display("FAIL fetch_ack_c2 got ack/stall/err/req=%b exp=1000", {if_ack, core_stall, if_err, mem_req});
    end
    checks++;
    if (if_rdata !== 32'h2002000A) begin failures++; $display("FAIL fetch_rdata got=%h exp=2002000a", if_rdata); end
    if_req = 0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got=%b exp=0", if_ack); end
  endtask

  task automatic test_store_waits();
    int busy, acks;
    bit done, seen;
    busy = 0; acks = 0; done = 0; seen = 0;
    mem_wait = 3;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        busy++;
        if (!seen) begin
          seen = 1;
          checks++;
          if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hCAFEF00D}) begin
            failures++; $display("FAIL store_mem got we=%b addr=%h wdata=%h exp 1/00000100/cafef00d", mem_we, mem_addr, mem_wdata);
          end
        end
      end
      if (d_ack) begin
        acks++; done = 1;
        checks++;
        if (d_err !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", d_err); end
        d_req = 0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (d_ack) acks++;
    end
    checks++;
    if (busy != 4) begin failures++; $display("FAIL store_busy_cycles got=%0d exp=4", busy); end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL store_ack_count got=%0d exp=1", acks); end
    d_we = 0;
    mem_wait = 0;
  endtask

  // Both requesters re-request immediately after each ack; fetch may pause for i_gap data acks.
  task automatic run_traffic(input int n, input int i_gap, output string order, output int bad);
    int acks, dcnt;
    bit pend;
    order = ""; bad = 0; acks = 0; dcnt = 0; pend = 0;
    d_we = 0; d_addr = 32'h2000; if_addr = 32'h1000;
    d_req = 1; if_req = 1;
    for (int c = 0; c < 300 && acks < n; c++) begin
      @(negedge clk);
      if (mem_req && (if_ack || d_ack)) bad++;
      if (if_ack && d_ack) bad++;
      if (d_ack) begin
        if (d_rdata !== (d_addr ^ rd_xor)) bad++;
        order = {order, "D"}; acks++; d_addr += 4; dcnt++;
        if (pend && dcnt >= i_gap) begin if_req = 1; pend = 0; end
      end
      if (if_ack) begin
        if (if_rdata !== (if_addr ^ rd_xor)) bad++;
        order = {order, "I"}; acks++; if_addr += 4;
        if (i_gap > 0) begin if_req = 0; pend = 1; dcnt = 0; end
      end
    end
    if (acks < n) bad += 1000;
    d_req = 0; if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    string order;
    int bad;
    do_reset();
    run_traffic(10, 0, order, bad);
    checks++;
    if (order != "DDDDIDDDDI") begin failures++; $display("FAIL starve_order got=%s exp=DDDDIDDDDI", order); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL starve_integrity got=%0d errors exp=0", bad); end
    checks++;
    if ({d_addr, if_addr} !== {32'h2020, 32'h1008}) begin
      failures++; $display("FAIL starve_counts got d=%h i=%h exp d=00002020 i=00001008", d_addr, if_addr);
    end
  endtask

  task automatic test_fetch_pause();
    string order;
    int bad;
    do_reset();
    run_traffic(12, 2, order, bad);
    checks++;
    if (order != "DDDDIDDDDDDI") begin failures++; $display("FAIL pause_order got=%s exp=DDDDIDDDDDDI", order); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL pause_integrity got=%0d errors exp=0", bad); end
  endtask

  task automatic test_reset_midflight();
    int acks;
    bit done;
    acks = 0; done = 0;
    mem_wait = 10;
    d_req = 1; d_we = 0; d_addr = 32'h140;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, d_ack} !== 2'b00) begin failures++; $display("FAIL rst_async got req/ack=%b exp=00", {mem_req, d_ack}); end
    mem_wait = 0;
    d_addr = 32'h180;
    @(negedge clk);
    if (d_ack) acks++;
    rst = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (d_ack) begin
        done = 1; acks++;
        checks++;
        if (d_rdata !== 32'h200201CA) begin failures++; $display("FAIL rst_fresh_rdata got=%h exp=200201ca", d_rdata); end
        d_req = 0;
      end
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL rst_fresh_acks got=%0d exp=1", acks); end
    @(negedge clk);
  endtask

  task automatic test_no_ready();
    int busy, acks;
    bit done;
    busy = 0; acks = 0; done = 0;
    mem_en = 0;
    d_req = 1; d_we = 0; d_addr = 32'h300;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (mem_req) busy++;
      if (d_ack) begin
        done = 1; acks++;
        checks++;
        if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
          failures++; $display("FAIL tmo_resp got err=%b rdata=%h exp err=1 rdata=0", d_err, d_rdata);
        end
        d_req = 0;
      end
    end
    checks++;
    if (busy != 8) begin failures++; $display("FAIL tmo_busy got=%0d exp=8", busy); end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL tmo_ack got=%0d exp=1", acks); end
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (d_ack || d_err) acks++;
    end
    checks++;
    if ({mem_req, core_stall} !== 2'b11) begin failures++; $display("FAIL wait_forever got req/stall=%b exp=11", {mem_req, core_stall}); end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL wait_no_ack got=%0d exp=0", acks); end
    d_req = 0;
    do_reset();
`endif
    mem_en = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_waits();
    test_starvation();
    test_fetch_pause();
    test_reset_midflight();
    test_no_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
